// File: rtl/div_pkg.sv
// Shared types and constants for the parametrised radix-4 divider.
package div_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    localparam int SKIP16 = 16;
    localparam int SKIP8  = 8;
    localparam int SKIP4  = 4;

    function automatic int bits_left_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_radix4_step.sv
// One restoring radix-4 step: pick the largest divisor multiple that fits.
module div_radix4_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+2:0] rem_i,
    input  logic [WIDTH+2:0] d1_i,
    input  logic [WIDTH+2:0] d2_i,
    input  logic [WIDTH+2:0] d3_i,
    output logic [WIDTH+2:0] rem_o,
    output logic [1:0]       digit_o
);
    logic [WIDTH+2:0] t1, t2, t3;

    assign t1 = rem_i - d1_i;
    assign t2 = rem_i - d2_i;
    assign t3 = rem_i - d3_i;

    // The top bit of each difference is its sign.
    always_comb begin
        rem_o   = rem_i;
        digit_o = 2'd0;
        if (!t3[WIDTH+2]) begin
            rem_o   = t3;
            digit_o = 2'd3;
        end else if (!t2[WIDTH+2]) begin
            rem_o   = t2;
            digit_o = 2'd2;
        end else if (!t1[WIDTH+2]) begin
            rem_o   = t1;
            digit_o = 2'd1;
        end
    end

endmodule

// File: rtl/div_core_param.sv
// Iterative radix-4 signed/unsigned divider with leading-zero skip and HI/LO result register.
// state | meaning:  S_IDLE | waiting for start,  S_RUN | iterating,  S_FIX | sign-correct and load C
module div_core_param
    import div_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit SKIP_EN = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               start,
    input  logic               sign,
    input  logic               cancel,
    input  logic [1:0]         WriteEnable,
    output logic [2*WIDTH-1:0] C,
    output logic               Busy,
    output logic               done,
    output logic               div_by_zero
);
    localparam int BLW = bits_left_w(WIDTH);
    localparam int RW  = WIDTH + 3;

    state_t           state_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q, araw_q, quo_q;
    logic [RW-1:0]    rem_q, d1_q, d2_q, d3_q;
    logic [BLW-1:0]   bits_q;
    logic             nega_q, negb_q, zero_q;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [RW-1:0]    d1_in, d2_in;
    logic [RW+15:0]   cand16;
    logic [RW+7:0]    cand8;
    logic [RW+3:0]    cand4;
    logic [RW-1:0]    r4, step_rem, rem_d;
    logic [1:0]       step_digit;
    logic [WIDTH-1:0] quo_d, r_mag, lo_fix, hi_fix;
    logic [BLW-1:0]   bits_d;

    assign neg_a = A[WIDTH-1] & sign;
    assign neg_b = B[WIDTH-1] & sign;
    assign mag_a = neg_a ? -A : A;
    assign mag_b = neg_b ? -B : B;
    assign d1_in = {3'b000, mag_b};
    assign d2_in = {d1_in[RW-2:0], 1'b0};

    // quo_q shifts dividend bits out the top while quotient digits enter at the bottom.
    assign cand16 = {rem_q, quo_q[WIDTH-1 -: SKIP16]};
    assign cand8  = {rem_q, quo_q[WIDTH-1 -: SKIP8]};
    assign cand4  = {rem_q, quo_q[WIDTH-1 -: SKIP4]};
    assign r4     = {rem_q[RW-3:0], quo_q[WIDTH-1 -: 2]};

    div_radix4_step #(.WIDTH(WIDTH)) u_step (
        .rem_i   (r4),
        .d1_i    (d1_q),
        .d2_i    (d2_q),
        .d3_i    (d3_q),
        .rem_o   (step_rem),
        .digit_o (step_digit)
    );

    always_comb begin
        rem_d  = step_rem;
        quo_d  = {quo_q[WIDTH-3:0], step_digit};
        bits_d = bits_q - BLW'(2);
        if (SKIP_EN && bits_q >= BLW'(SKIP16) && cand16 < {{SKIP16{1'b0}}, d1_q}) begin
            rem_d  = cand16[RW-1:0];
            quo_d  = quo_q << SKIP16;
            bits_d = bits_q - BLW'(SKIP16);
        end else if (SKIP_EN && bits_q >= BLW'(SKIP8) && cand8 < {{SKIP8{1'b0}}, d1_q}) begin
            rem_d  = cand8[RW-1:0];
            quo_d  = quo_q << SKIP8;
            bits_d = bits_q - BLW'(SKIP8);
        end else if (SKIP_EN && bits_q >= BLW'(SKIP4) && cand4 < {{SKIP4{1'b0}}, d1_q}) begin
            rem_d  = cand4[RW-1:0];
            quo_d  = quo_q << SKIP4;
            bits_d = bits_q - BLW'(SKIP4);
        end
    end

    assign r_mag  = rem_q[WIDTH-1:0];
    assign lo_fix = zero_q ? '1 : ((nega_q ^ negb_q) ? -quo_q : quo_q);
    assign hi_fix = zero_q ? araw_q : (nega_q ? -r_mag : r_mag);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            araw_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            bits_q  <= '0;
            nega_q  <= 1'b0;
            negb_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (cancel) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else if (start) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                nega_q  <= neg_a;
                negb_q  <= neg_b;
                zero_q  <= (B == '0);
                araw_q  <= A;
                quo_q   <= mag_a;
                rem_q   <= '0;
                d1_q    <= d1_in;
                d2_q    <= d2_in;
                d3_q    <= d1_in + d2_in;
                bits_q  <= BLW'(WIDTH);
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (zero_q || bits_q == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            rem_q  <= rem_d;
                            quo_q  <= quo_d;
                            bits_q <= bits_d;
                        end
                    end
                    S_FIX: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dbz_q   <= zero_q;
                        if (WriteEnable == 2'b00) begin
                            hi_q <= hi_fix;
                            lo_q <= lo_fix;
                        end
                    end
                    default: ;
                endcase
            end
            // A direct HI/LO write always lands, overriding a same-cycle result load.
            if (WriteEnable[1]) begin
                hi_q <= A;
            end else if (WriteEnable[0]) begin
                lo_q <= A;
            end
        end
    end

    assign C           = {hi_q, lo_q};
    assign Busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_core_param.sv
// Scoreboard bench for div_core_param: 32-bit (skip and no-skip) plus a 16-bit random run.
module tb_div_core_param;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] A, B;
    logic        start, sign, cancel;
    logic [1:0]  WriteEnable;
    logic [63:0] C, C_ns;
    logic        Busy, done, dbz, Busy_ns, done_ns, dbz_ns;

    logic [15:0] A16, B16;
    logic        start16, sign16, cancel16;
    logic [1:0]  we16;
    logic [31:0] C16;
    logic        Busy16, done16, dbz16;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [64:0] sb32[$];
    logic [32:0] sb16[$];
    logic [63:0] model_c;

    always #5 Clk = ~Clk;

    div_core_param #(.WIDTH(32), .SKIP_EN(1'b1)) u32 (
        .Clk(Clk), .Reset(Reset), .A(A), .B(B), .start(start), .sign(sign),
        .cancel(cancel), .WriteEnable(WriteEnable), .C(C), .Busy(Busy),
        .done(done), .div_by_zero(dbz)
    );

    div_core_param #(.WIDTH(32), .SKIP_EN(1'b0)) u32ns (
        .Clk(Clk), .Reset(Reset), .A(A), .B(B), .start(start), .sign(sign),
        .cancel(cancel), .WriteEnable(WriteEnable), .C(C_ns), .Busy(Busy_ns),
        .done(done_ns), .div_by_zero(dbz_ns)
    );

    div_core_param #(.WIDTH(16), .SKIP_EN(1'b1)) u16 (
        .Clk(Clk), .Reset(Reset), .A(A16), .B(B16), .start(start16), .sign(sign16),
        .cancel(cancel16), .WriteEnable(we16), .C(C16), .Busy(Busy16),
        .done(done16), .div_by_zero(dbz16)
    );

    function automatic logic [32:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic        na, nb;
        logic [15:0] ma, mb, q, r, qs, rs;
        if (b == 16'd0) return {a, 16'hFFFF, 1'b1};
        na = s & a[15];
        nb = s & b[15];
        ma = na ? (~a + 16'd1) : a;
        mb = nb ? (~b + 16'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        qs = (na ^ nb) ? (~q + 16'd1) : q;
        rs = na ? (~r + 16'd1) : r;
        return {rs, qs, 1'b0};
    endfunction

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge Clk);
        A = a; B = b; sign = s; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0; A = 32'hDEADBEEF; B = 32'h0BADF00D; sign = ~s;
    endtask

    task automatic wait_done(output int e32, output int ens, output int pulses,
                             output logic [64:0] got, output logic busy_at);
        e32 = -1; ens = -1; pulses = 0; got = 'x; busy_at = 1'bx;
        for (int e = 1; e <= 24; e++) begin
            @(posedge Clk); #1;
            if (done) begin
                pulses++;
                if (e32 < 0) begin
                    e32 = e; got = {C, dbz}; busy_at = Busy;
                end
            end
            if (done_ns && ens < 0) ens = e;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; A = '0; B = '0; start = 1'b0; sign = 1'b0; cancel = 1'b0; WriteEnable = 2'b00;
        A16 = '0; B16 = '0; start16 = 1'b0; sign16 = 1'b0; cancel16 = 1'b0; we16 = 2'b00;
        repeat (3) @(negedge Clk);
        tests_run++;
        if ({C, Busy, done, dbz} !== 67'd0) begin
            tests_failed++; $display("FAIL reset_hold got=%h exp=0", {C, Busy, done, dbz});
        end
        Reset = 1'b0;
        @(negedge Clk);
        tests_run++;
        if ({C, Busy, done, dbz, C16} !== 99'd0) begin
            tests_failed++; $display("FAIL reset_release got=%h exp=0", {C, Busy, done, dbz, C16});
        end
        model_c = 64'd0;
    endtask

    task automatic test_unsigned();
        int e32, ens, pulses; logic [64:0] got, exp; logic busy_at;
        sb32.push_back({32'd2, 32'd14, 1'b0});
        drive_start(32'd100, 32'd7, 1'b0);
        tests_run++;
        if (Busy !== 1'b1) begin tests_failed++; $display("FAIL unsigned_busy got=%b exp=1", Busy); end
        wait_done(e32, ens, pulses, got, busy_at);
        exp = sb32.pop_front();
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL unsigned_result got=%h exp=%h", got, exp); end
        tests_run++;
        if (pulses !== 1 || busy_at !== 1'b0) begin
            tests_failed++; $display("FAIL unsigned_done pulses=%0d busy=%b exp pulses=1 busy=0", pulses, busy_at);
        end
        model_c = exp[64:1];
    endtask

    task automatic test_signed();
        int e32, ens, pulses; logic [64:0] got, exp; logic busy_at;
        sb32.push_back({32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        drive_start(32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done(e32, ens, pulses, got, busy_at);
        exp = sb32.pop_front();
        tests_run++;
        if (got !== exp || pulses !== 1) begin
            tests_failed++; $display("FAIL signed_neg7_div2 got=%h pulses=%0d exp=%h", got, pulses, exp);
        end
        sb32.push_back({32'h00000000, 32'h80000000, 1'b0});
        drive_start(32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done(e32, ens, pulses, got, busy_at);
        exp = sb32.pop_front();
        tests_run++;
        if (got !== exp || pulses !== 1) begin
            tests_failed++; $display("FAIL signed_overflow got=%h pulses=%0d exp=%h", got, pulses, exp);
        end
        model_c = exp[64:1];
    endtask

    task automatic test_div_zero();
        int e32, ens, pulses; logic [64:0] got, exp; logic busy_at;
        sb32.push_back({32'h12345678, 32'hFFFFFFFF, 1'b1});
        drive_start(32'h12345678, 32'd0, 1'b0);
        wait_done(e32, ens, pulses, got, busy_at);
        exp = sb32.pop_front();
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL divzero_result got=%h exp=%h", got, exp); end
        tests_run++;
        if (e32 !== 2 || pulses !== 1) begin
            tests_failed++; $display("FAIL divzero_latency edge=%0d pulses=%0d exp edge=2 pulses=1", e32, pulses);
        end
        tests_run++;
        if (dbz !== 1'b0) begin tests_failed++; $display("FAIL divzero_flag_pulse got=%b exp=0", dbz); end
        model_c = exp[64:1];
    endtask

    task automatic test_latency();
        int e32, ens, pulses; logic [64:0] got, exp; logic busy_at;
        sb32.push_back({32'd0, 32'hFFFFFFFF, 1'b0});
        drive_start(32'hFFFFFFFF, 32'd1, 1'b0);
        wait_done(e32, ens, pulses, got, busy_at);
        exp = sb32.pop_front();
        tests_run++;
        if (got !== exp) begin tests_failed++; $display("FAIL lat_ffff_result got=%h exp=%h", got, exp); end
        tests_run++;
        if (e32 !== 18 || ens !== 18) begin
            tests_failed++; $display("FAIL lat_ffff_edge skip=%0d noskip=%0d exp 18/18", e32, ens);
        end
        sb32.push_back({32'd2, 32'd1, 1'b0});
        drive_start(32'd5, 32'd3, 1'b0);
        wait_done(e32, ens, pulses, got, busy_at);
        exp = sb32.pop_front();
        tests_run++;
        if (got !== exp || C_ns !== exp[64:1]) begin
            tests_failed++; $display("FAIL lat_5div3_result got=%h noskip=%h exp=%h", got, C_ns, exp);
        end
        tests_run++;
        if (e32 < 2 || e32 > 8 || ens !== 18) begin
            tests_failed++; $display("FAIL lat_5div3_edge skip=%0d noskip=%0d exp skip<=8 noskip=18", e32, ens);
        end
        model_c = exp[64:1];
    endtask

    task automatic test_cancel();
        int e32, ens, pulses; logic [64:0] got; logic busy_at;
        drive_start(32'hFFFFFFFF, 32'd1, 1'b0);
        repeat (2) @(posedge Clk);
        @(negedge Clk); cancel = 1'b1;
        @(posedge Clk); #1; cancel = 1'b0;
        tests_run++;
        if (Busy !== 1'b0 || C !== model_c) begin
            tests_failed++; $display("FAIL cancel_state busy=%b C=%h exp busy=0 C=%h", Busy, C, model_c);
        end
        wait_done(e32, ens, pulses, got, busy_at);
        tests_run++;
        if (pulses !== 0 || C !== model_c) begin
            tests_failed++; $display("FAIL cancel_no_done pulses=%0d C=%h exp pulses=0 C=%h", pulses, C, model_c);
        end
    endtask

    task automatic test_back_to_back();
        int e32, ens, pulses; logic [64:0] got, exp; logic busy_at;
        drive_start(32'hFFFFFFFF, 32'd1, 1'b0);
        repeat (4) @(posedge Clk);
        sb32.push_back({32'd1, 32'd2, 1'b0});
        drive_start(32'd9, 32'd4, 1'b0);
        wait_done(e32, ens, pulses, got, busy_at);
        exp = sb32.pop_front();
        tests_run++;
        if (got !== exp || pulses !== 1) begin
            tests_failed++; $display("FAIL restart got=%h pulses=%0d exp=%h pulses=1", got, pulses, exp);
        end
        model_c = exp[64:1];
    endtask

    task automatic test_write();
        logic [64:0] exp;
        sb32.push_back({32'hAAAA0000, model_c[31:0], 1'b1});
        drive_start(32'd5, 32'd0, 1'b0);
        @(posedge Clk);
        @(negedge Clk); A = 32'hAAAA0000; WriteEnable = 2'b10;
        @(posedge Clk); #1;
        WriteEnable = 2'b00;
        exp = sb32.pop_front();
        tests_run++;
        if ({C, dbz} !== exp || done !== 1'b1) begin
            tests_failed++; $display("FAIL write_on_fix got=%h done=%b exp=%h done=1", {C, dbz}, done, exp);
        end
        model_c = exp[64:1];
        @(negedge Clk); A = 32'h11111111; WriteEnable = 2'b11;
        @(posedge Clk); #1; WriteEnable = 2'b00;
        model_c[63:32] = 32'h11111111;
        tests_run++;
        if (C !== model_c) begin tests_failed++; $display("FAIL write_priority got=%h exp=%h", C, model_c); end
        @(negedge Clk); A = 32'h22222222; WriteEnable = 2'b01;
        @(posedge Clk); #1; WriteEnable = 2'b00;
        model_c[31:0] = 32'h22222222;
        tests_run++;
        if (C !== model_c) begin tests_failed++; $display("FAIL write_lo got=%h exp=%h", C, model_c); end
    endtask

    task automatic test_reset_mid();
        int e32, ens, pulses; logic [64:0] got, exp; logic busy_at;
        drive_start(32'hFFFFFFFF, 32'd1, 1'b0);
        repeat (4) @(posedge Clk);
        @(negedge Clk); #2;
        Reset = 1'b1;
        #1;
        tests_run++;
        if ({C, Busy, done, dbz} !== 67'd0) begin
            tests_failed++; $display("FAIL reset_async got=%h exp=0", {C, Busy, done, dbz});
        end
        @(negedge Clk); Reset = 1'b0;
        model_c = 64'd0;
        sb32.push_back({32'd2, 32'd14, 1'b0});
        drive_start(32'd100, 32'd7, 1'b0);
        wait_done(e32, ens, pulses, got, busy_at);
        exp = sb32.pop_front();
        tests_run++;
        if (got !== exp || pulses !== 1) begin
            tests_failed++; $display("FAIL reset_then_run got=%h pulses=%0d exp=%h", got, pulses, exp);
        end
        model_c = exp[64:1];
    endtask

    task automatic test_random16();
        logic [15:0] a, b;
        logic        s;
        logic [32:0] exp;
        int          sel, lat;
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 9);
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            if (sel == 0) b = 16'h0000;
            else if (sel == 1) b = 16'hFFFF;
            else if (sel == 2) a = 16'h8000;
            else if (sel == 3) begin a = 16'h8000; b = 16'hFFFF; end
            sb16.push_back(ref16(a, b, s));
            @(negedge Clk); A16 = a; B16 = b; sign16 = s; start16 = 1'b1;
            @(posedge Clk); #1; start16 = 1'b0; A16 = ~a; B16 = ~b;
            lat = -1;
            for (int e = 1; e <= 20; e++) begin
                @(posedge Clk); #1;
                if (done16) begin lat = e; break; end
            end
            exp = sb16.pop_front();
            tests_run++;
            if (lat < 0 || lat > 10 || (b == 16'd0 && lat != 2) || {C16, dbz16} !== exp) begin
                tests_failed++;
                $display("FAIL rand16 a=%h b=%h s=%b got=%h lat=%0d exp=%h", a, b, s, {C16, dbz16}, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_latency();
        test_cancel();
        test_back_to_back();
        test_write();
        test_reset_mid();
        test_random16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
